// File: rtl/frequency_pattern_generator_if.sv
// Register-operation bus shared with the AXI slave: the host side drives operation, index and
// write data, the generator returns registered read data.
interface frequency_pattern_generator_if;
  logic [1:0]  register_operation;  // 0 none, 1 read, 2 write
  logic [7:0]  register_number;
  logic [31:0] register_write;
  logic [31:0] register_read;

  modport master (
    output register_operation,
    output register_number,
    output register_write,
    input  register_read
  );

  modport slave (
    input  register_operation,
    input  register_number,
    input  register_write,
    output register_read
  );
endinterface

// File: rtl/frequency_pattern_generator.sv
// frequency_pattern_generator: stimulus source for the pixel frequency analyzer.
// Emits a pixel stream whose bit 7 carries three square-wave tones at fixed pixel indices, and
// frames each run with a start pulse and a held stop level.
// Optional build macro PATTERN_GEN_NOISE_EN: data[6:0] carries a 7-bit LFSR (x^7+x^6+1) that
// advances per pixel strobe; otherwise data[6:0] is tied to 0.
module frequency_pattern_generator #(
  parameter int unsigned PIXELS_PER_LINE = 1024,
  parameter int unsigned PIXEL0_INDEX    = 63,
  parameter int unsigned PIXEL1_INDEX    = 511,
  parameter int unsigned PIXEL2_INDEX    = 1023,
  parameter int unsigned PIXEL_DIVIDER   = 4,   // >= 2
  parameter int unsigned STOP_HOLD       = 16   // >= 7
) (
  input  logic                         s00_axi_aclk,
  input  logic                         s00_axi_aresetn,
  frequency_pattern_generator_if.slave reg_if,
  output logic [7:0]                   data,
  output logic                         pixel_strobe,
  output logic                         start,
  output logic                         stop,
  output logic                         busy
);

  localparam int unsigned PixW  = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
  localparam int unsigned DivW  = $clog2(PIXEL_DIVIDER);
  localparam int unsigned StopW = $clog2(STOP_HOLD);

  localparam logic [PixW-1:0]  PixLast  = PixW'(PIXELS_PER_LINE - 1);
  localparam logic [PixW-1:0]  PixTone0 = PixW'(PIXEL0_INDEX);
  localparam logic [PixW-1:0]  PixTone1 = PixW'(PIXEL1_INDEX);
  localparam logic [PixW-1:0]  PixTone2 = PixW'(PIXEL2_INDEX);
  localparam logic [DivW-1:0]  DivLast  = DivW'(PIXEL_DIVIDER - 1);
  localparam logic [StopW-1:0] StopLast = StopW'(STOP_HOLD - 1);

  localparam logic [7:0] RegCtrl   = 8'd0;
  localparam logic [7:0] RegHp0    = 8'd1;
  localparam logic [7:0] RegHp1    = 8'd2;
  localparam logic [7:0] RegHp2    = 8'd3;
  localparam logic [7:0] RegRunLen = 8'd4;
  localparam logic [7:0] RegStatus = 8'd5;

  typedef enum logic [1:0] {StIdle, StStart, StRun, StStop} state_e;

  state_e state_q, state_d;

  // Host-visible configuration and the per-run shadow copies
  logic [2:0][31:0] hp_q, hp_d;
  logic [31:0]      len_q, len_d;
  logic [2:0][31:0] sh_hp_q, sh_hp_d;
  logic [31:0]      sh_len_q, sh_len_d;
  logic [31:0]      rd_q, rd_d;
  logic [23:0]      runs_q, runs_d;

  // Run timing and pattern state
  logic [31:0]      run_cnt_q, run_cnt_d;
  logic [StopW-1:0] stop_cnt_q, stop_cnt_d;
  logic [2:0][31:0] tone_cnt_q, tone_cnt_d;
  logic [2:0]       tone_q, tone_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [PixW-1:0]  pix_q, pix_d;

  // Registered outputs
  logic [7:0] data_q, data_d;
  logic       strobe_q, strobe_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;

  logic wr_en, rd_en, run_req, abort_req;
  logic [6:0] noise;

  // Decode the register-operation port
  always_comb begin
    wr_en     = (reg_if.register_operation == 2'd2);
    rd_en     = (reg_if.register_operation == 2'd1);
    run_req   = wr_en && (reg_if.register_number == RegCtrl) && reg_if.register_write[0];
    abort_req = wr_en && (reg_if.register_number == RegCtrl) && reg_if.register_write[1];
  end

  // State register
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RUN and ABORT are only honoured in the state where they make sense
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run_req) state_d = StStart;
      StStart: state_d = (sh_len_q == '0) ? StStop : StRun;
      StRun: begin
        if (abort_req || (run_cnt_q == sh_len_q - 32'd1)) state_d = StStop;
      end
      StStop:  if (stop_cnt_q == StopLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, computed from the next state so they line up with it once registered
  always_comb begin
    start_d = (state_d == StStart);
    stop_d  = (state_d == StStop);
    busy_d  = (state_d != StIdle);
  end

  // Configuration writes and registered reads
  always_comb begin
    hp_d  = hp_q;
    len_d = len_q;
    rd_d  = rd_q;
    if (wr_en) begin
      case (reg_if.register_number)
        RegHp0:    hp_d[0] = reg_if.register_write;
        RegHp1:    hp_d[1] = reg_if.register_write;
        RegHp2:    hp_d[2] = reg_if.register_write;
        RegRunLen: len_d   = reg_if.register_write;
        default:   ;
      endcase
    end
    if (rd_en) begin
      case (reg_if.register_number)
        RegHp0:    rd_d = hp_q[0];
        RegHp1:    rd_d = hp_q[1];
        RegHp2:    rd_d = hp_q[2];
        RegRunLen: rd_d = len_q;
        RegStatus: rd_d = {runs_q, 7'd0, busy_q};
        default:   rd_d = '0;
      endcase
    end
  end

  // Run counters, tone generators and pixel divider
  always_comb begin
    sh_hp_d    = sh_hp_q;
    sh_len_d   = sh_len_q;
    runs_d     = runs_q;
    run_cnt_d  = '0;
    stop_cnt_d = '0;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    div_d      = div_q;
    pix_d      = pix_q;
    strobe_d   = 1'b0;
    unique case (state_q)
      StIdle, StStart: begin
        tone_cnt_d = '0;
        tone_d     = '0;
        div_d      = '0;
        pix_d      = '0;
        if (state_q == StIdle && state_d == StStart) begin
          sh_hp_d  = hp_q;
          sh_len_d = len_q;
        end
      end
      StRun: begin
        run_cnt_d = run_cnt_q + 32'd1;
        for (int i = 0; i < 3; i++) begin
          // A zero half-period leaves the tone parked at 0
          if (sh_hp_q[i] != '0) begin
            if (tone_cnt_q[i] == sh_hp_q[i] - 32'd1) begin
              tone_cnt_d[i] = '0;
              tone_d[i]     = ~tone_q[i];
            end else begin
              tone_cnt_d[i] = tone_cnt_q[i] + 32'd1;
            end
          end
        end
        if (div_q == DivLast) begin
          div_d    = '0;
          pix_d    = (pix_q == PixLast) ? '0 : pix_q + PixW'(1);
          // No strobe may land in the first STOP cycle
          strobe_d = (state_d == StRun);
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StStop: begin
        stop_cnt_d = stop_cnt_q + StopW'(1);
        if (state_d == StIdle) runs_d = runs_q + 24'd1;
      end
      default: ;
    endcase
  end

`ifdef PATTERN_GEN_NOISE_EN
  logic [6:0] lfsr_q, lfsr_d;

  // Noise LFSR: reseeded in START so every run starts from the same sequence
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == StStart) begin
      lfsr_d = 7'h01;
    end else if (strobe_d) begin
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end
    noise = lfsr_d;
  end

  // Noise LFSR register
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Low bits carry nothing without the noise option
  always_comb begin
    noise = '0;
  end
`endif

  // Pixel value: tone of the pixel about to be shown; lowest tone wins on shared indices
  always_comb begin
    data_d = '0;
    if (state_d == StRun) begin
      if (pix_d == PixTone0) begin
        data_d[7] = tone_d[0];
      end else if (pix_d == PixTone1) begin
        data_d[7] = tone_d[1];
      end else if (pix_d == PixTone2) begin
        data_d[7] = tone_d[2];
      end
      data_d[6:0] = noise;
    end
  end

  // Datapath and output registers
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      hp_q       <= '0;
      len_q      <= '0;
      sh_hp_q    <= '0;
      sh_len_q   <= '0;
      rd_q       <= '0;
      runs_q     <= '0;
      run_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tone_cnt_q <= '0;
      tone_q     <= '0;
      div_q      <= '0;
      pix_q      <= '0;
      data_q     <= '0;
      strobe_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      hp_q       <= hp_d;
      len_q      <= len_d;
      sh_hp_q    <= sh_hp_d;
      sh_len_q   <= sh_len_d;
      rd_q       <= rd_d;
      runs_q     <= runs_d;
      run_cnt_q  <= run_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      div_q      <= div_d;
      pix_q      <= pix_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  assign reg_if.register_read = rd_q;
  assign data                 = data_q;
  assign pixel_strobe         = strobe_q;
  assign start                = start_q;
  assign stop                 = stop_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_frequency_pattern_generator.sv
// Self-checking bench for frequency_pattern_generator. Expected outputs come from a closed-form
// model of a run: cycle r after the RUN write maps to a phase (start / run / stop / idle), and
// within RUN the pixel and tone values follow from plain division of the elapsed time.
module tb_frequency_pattern_generator;
  localparam int Div  = 4;
  localparam int Ppl  = 1024;
  localparam int Pix0 = 63;
  localparam int Pix1 = 511;
  localparam int Pix2 = 1023;
  localparam int Hold = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] data;
  logic       pixel_strobe, start, stop, busy;

  int n_total = 0;
  int n_pass  = 0;
  int runs_done = 0;

  frequency_pattern_generator_if bus_if ();

  frequency_pattern_generator dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rstn),
    .reg_if         (bus_if.slave),
    .data           (data),
    .pixel_strobe   (pixel_strobe),
    .start          (start),
    .stop           (stop),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Expected {data, pixel_strobe, start, stop, busy} in cycle r after the RUN write edge
  // (r = 1 is the start cycle) for a run lasting len RUN cycles.
  function automatic logic [11:0] model_out(int r, int h0, int h1, int h2, int len);
    logic [7:0] d;
    logic stb, st, sp, bz;
    int u, pix;
`ifdef PATTERN_GEN_NOISE_EN
    logic [6:0] l;
`endif
    d = '0; stb = 1'b0; st = 1'b0; sp = 1'b0; bz = 1'b0;
    if (r == 1) begin
      st = 1'b1; bz = 1'b1;
    end else if (r >= 2 && r <= len + 1) begin
      u   = r - 2;
      pix = (u / Div) % Ppl;
      bz  = 1'b1;
      stb = (u != 0) && (u % Div == 0);
      if (pix == Pix0)      d[7] = (h0 != 0) && ((u / h0) % 2 == 1);
      else if (pix == Pix1) d[7] = (h1 != 0) && ((u / h1) % 2 == 1);
      else if (pix == Pix2) d[7] = (h2 != 0) && ((u / h2) % 2 == 1);
`ifdef PATTERN_GEN_NOISE_EN
      l = 7'h01;
      for (int s = 0; s < (u / Div) % 127; s++) l = {l[5:0], l[6] ^ l[5]};
      d[6:0] = l;
`endif
    end else if (r >= len + 2 && r <= len + 1 + Hold) begin
      sp = 1'b1; bz = 1'b1;
    end
    return {d, stb, st, sp, bz};
  endfunction

  task automatic write_reg(input logic [7:0] num, input logic [31:0] val);
    bus_if.register_operation = 2'd2;
    bus_if.register_number    = num;
    bus_if.register_write     = val;
    @(negedge clk);
    bus_if.register_operation = 2'd0;
  endtask

  task automatic read_reg(input logic [7:0] num, output logic [31:0] val);
    bus_if.register_operation = 2'd1;
    bus_if.register_number    = num;
    @(negedge clk);
    val = bus_if.register_read;
    bus_if.register_operation = 2'd0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rstn = 1'b0;
    bus_if.register_operation = 2'd0;
    bus_if.register_number    = '0;
    bus_if.register_write     = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({data, pixel_strobe, start, stop, busy} !== 12'h000)
        $display("FAIL reset_outputs cyc=%0d got %h expected 000", i,
                 {data, pixel_strobe, start, stop, busy});
      else n_pass++;
    end
    rstn = 1'b1;
    runs_done = 0;
    read_reg(8'd5, rd);
    n_total++;
    if (rd !== 32'd0) $display("FAIL reset_status got %h expected 0", rd);
    else n_pass++;
  endtask

  task automatic test_registers();
    logic [31:0] vals [4];
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      write_reg(8'(i + 1), vals[i]);
    end
    write_reg(8'd5, $urandom);
    write_reg(8'($urandom_range(6, 255)), $urandom);
    write_reg(8'd0, $urandom & 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      read_reg(8'(i + 1), rd);
      n_total++;
      if (rd !== vals[i]) $display("FAIL reg_readback idx=%0d got %h expected %h", i + 1, rd, vals[i]);
      else n_pass++;
    end
    // Read data must hold while no read is issued
    write_reg(8'd200, $urandom);
    n_total++;
    if (bus_if.register_read !== vals[3])
      $display("FAIL read_hold got %h expected %h", bus_if.register_read, vals[3]);
    else n_pass++;
    read_reg(8'd0, rd);
    n_total++;
    if (rd !== 32'd0) $display("FAIL ctrl_read got %h expected 0", rd);
    else n_pass++;
    read_reg(8'd5, rd);
    n_total++;
    if (rd !== 32'd0) $display("FAIL status_idle got %h expected 0", rd);
    else n_pass++;
    read_reg(8'($urandom_range(6, 255)), rd);
    n_total++;
    if (rd !== 32'd0) $display("FAIL unmapped_read got %h expected 0", rd);
    else n_pass++;
    n_total++;
    if ({data, pixel_strobe, start, stop, busy} !== 12'h000)
      $display("FAIL no_spurious_run got %h expected 000", {data, pixel_strobe, start, stop, busy});
    else n_pass++;
  endtask

  task automatic test_plan_run();
    logic [11:0] exp;
    logic [31:0] rd;
    int fails = 0;
    write_reg(8'd1, 32'd100);
    write_reg(8'd2, 32'd0);
    write_reg(8'd3, 32'd50);
    write_reg(8'd4, 32'd10000);
    write_reg(8'd0, 32'd1);
    for (int r = 1; r <= 10000 + Hold + 4; r++) begin
      exp = model_out(r, 100, 0, 50, 10000);
      n_total++;
      if ({data, pixel_strobe, start, stop, busy} !== exp)
        $display("FAIL plan_run r=%0d got %h expected %h", r,
                 {data, pixel_strobe, start, stop, busy}, exp);
      else n_pass++;
      @(negedge clk);
    end
    runs_done++;
    read_reg(8'd5, rd);
    n_total++;
    if (rd !== {8'(runs_done), 24'd0} >> 0 >> 0 && rd !== 32'(runs_done) << 8)
      $display("FAIL plan_status got %h expected %h", rd, 32'(runs_done) << 8);
    else n_pass++;
  endtask

  task automatic test_short_lengths();
    logic [11:0] exp;
    for (int len = 0; len <= 1; len++) begin
      write_reg(8'd4, 32'(len));
      write_reg(8'd0, 32'd1);
      for (int r = 1; r <= len + Hold + 4; r++) begin
        exp = model_out(r, 100, 0, 50, len);
        n_total++;
        if ({data, pixel_strobe, start, stop, busy} !== exp)
          $display("FAIL short_len len=%0d r=%0d got %h expected %h", len, r,
                   {data, pixel_strobe, start, stop, busy}, exp);
        else n_pass++;
        @(negedge clk);
      end
      runs_done++;
    end
  endtask

  task automatic test_random_runs();
    logic [11:0] exp;
    logic [31:0] rd;
    int h [3];
    int len;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 3; i++) h[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
      len = $urandom_range(260, 900);
      for (int i = 0; i < 3; i++) write_reg(8'(i + 1), 32'(h[i]));
      write_reg(8'd4, 32'(len));
      write_reg(8'd0, 32'd1);
      for (int r = 1; r <= len + Hold + 3; r++) begin
        exp = model_out(r, h[0], h[1], h[2], len);
        n_total++;
        if ({data, pixel_strobe, start, stop, busy} !== exp)
          $display("FAIL random_run n=%0d r=%0d got %h expected %h", n, r,
                   {data, pixel_strobe, start, stop, busy}, exp);
        else n_pass++;
        @(negedge clk);
      end
      runs_done++;
    end
    read_reg(8'd5, rd);
    n_total++;
    if (rd !== 32'(runs_done) << 8) $display("FAIL run_count got %h expected %h", rd, 32'(runs_done) << 8);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [11:0] exp;
    logic [31:0] rd;
    int h0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    runs_done = 0;
    h0 = $urandom_range(1, 90);
    write_reg(8'd1, 32'(h0));
    write_reg(8'd4, 32'd1000);
    write_reg(8'd0, 32'd1);
    // ABORT driven at r = 201 is sampled at the edge closing RUN cycle 200
    for (int r = 1; r <= 200 + Hold + 4; r++) begin
      exp = model_out(r, h0, 0, 0, 200);
      n_total++;
      if ({data, pixel_strobe, start, stop, busy} !== exp)
        $display("FAIL abort r=%0d got %h expected %h", r, {data, pixel_strobe, start, stop, busy}, exp);
      else n_pass++;
      if (r == 201) begin
        bus_if.register_operation = 2'd2;
        bus_if.register_number    = 8'd0;
        bus_if.register_write     = 32'd2;
      end else begin
        bus_if.register_operation = 2'd0;
      end
      @(negedge clk);
    end
    runs_done++;
    read_reg(8'd5, rd);
    n_total++;
    if (rd !== 32'h0000_0100) $display("FAIL abort_count got %h expected 00000100", rd);
    else n_pass++;
  endtask

  task automatic test_busy_rewrite();
    logic [11:0] exp;
    logic [31:0] rd;
    write_reg(8'd1, 32'd70);
    write_reg(8'd4, 32'd600);
    write_reg(8'd0, 32'd1);
    for (int r = 1; r <= 600 + Hold + 3; r++) begin
      exp = model_out(r, 70, 0, 0, 600);
      n_total++;
      if ({data, pixel_strobe, start, stop, busy} !== exp)
        $display("FAIL busy_rewrite r=%0d got %h expected %h", r,
                 {data, pixel_strobe, start, stop, busy}, exp);
      else n_pass++;
      bus_if.register_operation = (r == 50 || r == 80) ? 2'd2 : 2'd0;
      bus_if.register_number    = (r == 50) ? 8'd0 : 8'd1;
      bus_if.register_write     = (r == 50) ? 32'd1 : 32'd126;
      @(negedge clk);
    end
    bus_if.register_operation = 2'd0;
    runs_done++;
    read_reg(8'd1, rd);
    n_total++;
    if (rd !== 32'd126) $display("FAIL hp0_updated got %h expected 126", rd);
    else n_pass++;
    write_reg(8'd4, 32'd300);
    write_reg(8'd0, 32'd1);
    for (int r = 1; r <= 300 + Hold + 3; r++) begin
      exp = model_out(r, 126, 0, 0, 300);
      n_total++;
      if ({data, pixel_strobe, start, stop, busy} !== exp)
        $display("FAIL next_run_hp r=%0d got %h expected %h", r,
                 {data, pixel_strobe, start, stop, busy}, exp);
      else n_pass++;
      @(negedge clk);
    end
    runs_done++;
    read_reg(8'd5, rd);
    n_total++;
    if (rd !== 32'(runs_done) << 8) $display("FAIL rewrite_count got %h expected %h", rd, 32'(runs_done) << 8);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    logic [11:0] exp;
    logic [31:0] rd;
    write_reg(8'd4, 32'd1000);
    write_reg(8'd0, 32'd1);
    for (int r = 1; r <= 150; r++) begin
      exp = model_out(r, 126, 0, 0, 1000);
      n_total++;
      if ({data, pixel_strobe, start, stop, busy} !== exp)
        $display("FAIL pre_reset r=%0d got %h expected %h", r, {data, pixel_strobe, start, stop, busy}, exp);
      else n_pass++;
      @(negedge clk);
    end
    rstn = 1'b0;
    for (int i = 0; i < 3 + 30; i++) begin
      @(negedge clk);
      if (i == 2) rstn = 1'b1;
      n_total++;
      if ({data, pixel_strobe, start, stop, busy} !== 12'h000)
        $display("FAIL midrun_reset i=%0d got %h expected 000", i, {data, pixel_strobe, start, stop, busy});
      else n_pass++;
    end
    runs_done = 0;
    read_reg(8'd5, rd);
    n_total++;
    if (rd !== 32'd0) $display("FAIL midrun_status got %h expected 0", rd);
    else n_pass++;
    read_reg(8'd9, rd);
    n_total++;
    if (rd !== 32'd0) $display("FAIL midrun_reg9 got %h expected 0", rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_registers();
    test_plan_run();
    test_short_lengths();
    test_random_runs();
    test_abort();
    test_busy_rewrite();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frequency_pattern_generator.md
# frequency_pattern_generator

Stimulus source for the pixel frequency analyzer path. The host programs it through the same register-operation port the AXI slave exposes. It emits an 8-bit pixel stream with a pixel strobe, in which three configured pixel indices carry square-wave tones on bit 7. It also drives the analyzer's `start` and `stop` control lines, framing a run of programmed length. It is the transmitting end of the analyzer's sampling and handshake interface, used for bring-up and self-test.

## Interface
Parameters:
- `PIXELS_PER_LINE`, 1024: pixel counter modulus.
- `PIXEL0_INDEX`, 63: pixel index carrying tone 0.
- `PIXEL1_INDEX`, 511: pixel index carrying tone 1.
- `PIXEL2_INDEX`, 1023: pixel index carrying tone 2.
- `PIXEL_DIVIDER`, 4: clocks per pixel; must be ≥ 2.
- `STOP_HOLD`, 16: cycles `stop` stays high; must be ≥ 7 so the analyzer can flush its 6 registers.

Ports:
- `s00_axi_aclk`, in, 1: the single clock.
- `s00_axi_aresetn`, in, 1: reset; synchronous, active-low.
- `register_operation`, in, 2: 0 = none, 1 = read, 2 = write.
- `register_number`, in, 8: register index.
- `register_write`, in, 32: write data.
- `register_read`, out, 32: read data, registered.
- `data`, out, 8: pixel value.
- `pixel_strobe`, out, 1: one-cycle pulse per pixel advance; feeds the analyzer's `pixel_clock`.
- `start`, out, 1: one-cycle run-start pulse.
- `stop`, out, 1: run-end level, held `STOP_HOLD` cycles.
- `busy`, out, 1: high from the `start` cycle through the last `stop` cycle.

## Operation
Registers. Writes take effect only when `register_operation` == 2. Writes to indices ≥ 6, and to register 5, are ignored.
- 0, CONTROL:
  - bit0 RUN: writing 1 in IDLE launches a run; ignored when busy.
  - bit1 ABORT: self-clearing.
  - Reads 0.
- 1, 2, 3, HALF_PERIOD0..2: tone half-period in clocks. 0 disables the tone, holding it at 0.
- 4, RUN_LENGTH: RUN state duration in clocks.
- 5, STATUS (read-only):
  - bit0 = `busy`.
  - bits[31:8] = completed-run count, 24-bit wrapping; aborted runs are counted.
- Reads: `register_operation` == 1 loads `register_read` on the next edge. Unmapped indices read 0. Otherwise `register_read` holds its last value.

State machine (IDLE, START, RUN, STOP):
- IDLE → START: on a RUN write. Shadow copies of HALF_PERIOD0..2 and RUN_LENGTH are latched; writes during a run affect only the next run. Tones, tone counters, pixel counter and divider counter all clear.
- START → RUN: after 1 cycle, with `start` = 1 during START.
- RUN → STOP: after shadow RUN_LENGTH cycles. A RUN_LENGTH of 0 skips RUN (START → STOP directly). An ABORT write in RUN → STOP on the next edge.
- STOP → IDLE: after `STOP_HOLD` cycles, with `stop` = 1 throughout. The completed-run count increments on the STOP → IDLE edge.

Tones:
- Each enabled tone has a counter that runs in RUN only.
- When the counter reaches half-period − 1, the tone toggles and the counter wraps to 0.
- Tones freeze in STOP and clear in IDLE.

Pixel stream:
- Active in RUN only.
- The divider counts 0..`PIXEL_DIVIDER`−1. On the wrap, `pixel_strobe` pulses and the pixel counter advances, wrapping `PIXELS_PER_LINE`−1 → 0.
- `data`[7] is the tone whose index equals the pixel counter, otherwise 0. `data`[6:0] is 0.
- If indices coincide, the lowest-numbered tone wins.
- Outside RUN: `data` = 0, `pixel_strobe` = 0.

## Timing
- Reset: all outputs are 0 at the first edge with `s00_axi_aresetn` low. State returns to IDLE and all registers clear, including the run count. This is also the required behaviour for reset mid-run: no `stop` is emitted afterwards.
- Write to register 0 sampled at edge k: `start` is high in cycle k+1, RUN is cycles k+2 .. k+1+RUN_LENGTH, and `stop` follows for `STOP_HOLD` cycles.
- First `pixel_strobe` occurs `PIXEL_DIVIDER` cycles after RUN entry.
- Tone periods are exactly 2×half-period clocks.
- The outputs `data`, `pixel_strobe`, `start`, `stop` and `busy` are registered.
- Read latency is 1 clock.

## Configuration
- `PATTERN_GEN_NOISE_EN` defined:
  - `data`[6:0] carries a 7-bit maximal LFSR (x^7+x^6+1, seed 7'h01).
  - The LFSR advances on each `pixel_strobe`.
  - It reseeds at START.
  - This proves the analyzer uses bit 7 only.
- Not defined: `data`[6:0] is constantly 0.

## Test plan
- Reset with `s00_axi_aresetn` low for 3 cycles → all outputs 0, STATUS reads 0.
- Program HALF_PERIOD0=100, HALF_PERIOD1=0, HALF_PERIOD2=50, RUN_LENGTH=10000, then RUN → the following must all hold:
  - `start` pulses once.
  - `data`[7] at pixel 63 toggles every 100 clocks and at pixel 1023 every 50 clocks.
  - Pixel 511 stays 0.
  - `stop` is high for 16 cycles starting at cycle 10002.
- RUN_LENGTH=0 → `start` is followed immediately by `stop`, and no `pixel_strobe` occurs.
- ABORT written 200 cycles into a run → `stop` rises on the next cycle, and STATUS run count is 1 after `busy` falls.
- RUN written while busy, and HALF_PERIOD0 changed mid-run → the duplicate RUN is ignored, and the new half-period applies only to the next run.
- Reset asserted mid-RUN → outputs are 0 next edge, with no `stop`. Reads of registers 5 and 9 return 0.
